n2_com_dp_32x152_fifo_ctl: RTL and testbench

- FIFO sequencer for one 32-entry x 152-bit two-port register-file array (write port + registered read port, 1-cycle read latency).
- Accepts a push stream and issues array write enables/addresses; prefetches array entries into a 2-entry output skid so pop data streams at 1 entry/cycle with valid/ready.
- Sits between a producer datapath and consumer in the SPC/IOP pipelines; array instance lives beside it.

---
 rtl/n2_com_fifo_pkg.sv | 16 +
 rtl/n2_com_skid2.sv | 67 ++++++
 rtl/n2_com_dp_32x152_fifo_ctl.sv | 93 +++++++++
 tb/tb_n2_com_dp_32x152_fifo_ctl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n2_com_fifo_pkg.sv
// Shared constants and types for the 32-entry x 152-bit FIFO controller.
//   DEPTH : array entries (power of two)
//   AW    : array address width
//   DW    : entry data width
//   CW    : width of occupancy counters (holds 0..DEPTH+2)
package n2_com_fifo_pkg;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 152;
   localparam int unsigned CW    = AW + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/n2_com_skid2.sv
// Two-entry valid/ready output skid that sits behind a registered-read array.
// An entry arriving on i_in_vld is visible at the output in the same cycle
// when the skid is empty, so a read issued in cycle N can pop in cycle N+1.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_in_vld       : array read data arriving this cycle
//   i_in_data      : array read data
//   o_out_vld      : head entry valid
//   i_out_rdy      : consumer takes head
//   o_out_data     : head entry data (zero when nothing valid)
//   o_occ          : stored entries (0..2), excludes the arriving entry
module n2_com_skid2 #(
   parameter int unsigned DW = 152
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_in_vld,
   input  logic [DW-1:0] i_in_data,
   output logic          o_out_vld,
   input  logic          i_out_rdy,
   output logic [DW-1:0] o_out_data,
   output logic [1:0]    o_occ
);

   logic [DW-1:0] r_mem [2];
   logic          r_head;
   logic [1:0]    r_occ;

   logic          w_pop;
   logic          w_bypass;
   logic          w_store;
   logic          w_tail;

   assign o_out_vld = !i_reset && ((r_occ != 2'd0) || i_in_vld);
   assign w_pop     = o_out_vld && i_out_rdy;
   // Arriving entry consumed directly when nothing is stored ahead of it.
   assign w_bypass  = w_pop && (r_occ == 2'd0);
   assign w_store   = i_in_vld && !w_bypass;
   assign w_tail    = r_head ^ r_occ[0];
   assign o_occ     = r_occ;

   // Head is the oldest stored entry; fall through to the arriving entry.
   always_comb begin
      o_out_data = '0;
      if (r_occ != 2'd0)
         o_out_data = r_mem[r_head];
      else if (i_in_vld)
         o_out_data = i_in_data;
   end

   // Storage, head pointer and occupancy.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mem  <= '{default: '0};
         r_head <= 1'b0;
         r_occ  <= 2'd0;
      end else begin
         if (w_store)
            r_mem[w_tail] <= i_in_data;
         if (w_pop && (r_occ != 2'd0))
            r_head <= ~r_head;
         r_occ <= r_occ + 2'(i_in_vld) - 2'(w_pop);
         assert (!(w_store && !w_pop && (r_occ == 2'd2)));
         assert (r_occ != 2'd3);
      end
   end

endmodule

// File: rtl/n2_com_dp_32x152_fifo_ctl.sv
// FIFO sequencer for a 32 x 152 two-port register file with a registered
// read port. Converts a push stream into array writes, prefetches entries
// into a 2-entry output skid and presents them with valid/ready.
//   l2clk, reset : clock, synchronous active-high reset
//   push_vld/rdy : producer handshake (write data goes straight to the array)
//   wr_en/wr_adr : array write port control
//   rd_en/rd_adr : array read port control (data on arr_dout next cycle)
//   arr_dout     : array read data
//   wr_inhibit   : test/BIST write inhibit, blocks pushes only
//   pop_vld/rdy  : consumer handshake, pop_data is the head entry
//   count        : entries held in array + in-flight read + skid
//   empty        : count == 0
//   full         : array holds DEPTH entries
module n2_com_dp_32x152_fifo_ctl
   import n2_com_fifo_pkg::*;
(
   input  logic          l2clk,
   input  logic          reset,
   input  logic          push_vld,
   output logic          push_rdy,
   output logic          wr_en,
   output logic [AW-1:0] wr_adr,
   output logic          rd_en,
   output logic [AW-1:0] rd_adr,
   input  logic [DW-1:0] arr_dout,
   input  logic          wr_inhibit,
   output logic          pop_vld,
   input  logic          pop_rdy,
   output logic [DW-1:0] pop_data,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full
);

   ptr_t       r_wptr;
   ptr_t       r_rptr;
   cnt_t       r_arr_cnt;
   logic       r_rd_inflight;

   logic [1:0] w_occ;
   logic       w_pop;
   logic [1:0] w_pend;

   // Full comes from the registered array count only; a read in the same
   // cycle does not open a slot for a push.
   assign full     = (r_arr_cnt == CW'(DEPTH));
   assign push_rdy = !reset && !full && !wr_inhibit;
   assign wr_en    = push_vld && push_rdy;
   assign wr_adr   = r_wptr;

   // Skid slots that will be committed after this cycle's pop; a new read
   // may only be issued while at least one slot remains for its data.
   assign w_pop  = pop_vld && pop_rdy;
   assign w_pend = w_occ + 2'(r_rd_inflight) - 2'(w_pop);
   assign rd_en  = !reset && (r_arr_cnt != '0) && (w_pend < 2'd2);
   assign rd_adr = r_rptr;

   assign count = r_arr_cnt + CW'(r_rd_inflight) + CW'(w_occ);
   assign empty = (count == '0);

   // Pointers, array occupancy and read-in-flight tracking.
   always_ff @(posedge l2clk) begin
      if (reset) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_arr_cnt     <= '0;
         r_rd_inflight <= 1'b0;
      end else begin
         r_wptr        <= r_wptr + AW'(wr_en);
         r_rptr        <= r_rptr + AW'(rd_en);
         r_arr_cnt     <= r_arr_cnt + CW'(wr_en) - CW'(rd_en);
         r_rd_inflight <= rd_en;
         assert (!(wr_en && full));
         assert (!(rd_en && (r_arr_cnt == '0)));
         assert (r_arr_cnt <= CW'(DEPTH));
      end
   end

   // Output skid; array data is captured the cycle after rd_en.
   n2_com_skid2 #(
      .DW (DW)
   ) u_skid (
      .i_clk      (l2clk),
      .i_reset    (reset),
      .i_in_vld   (r_rd_inflight),
      .i_in_data  (arr_dout),
      .o_out_vld  (pop_vld),
      .i_out_rdy  (pop_rdy),
      .o_out_data (pop_data),
      .o_occ      (w_occ)
   );

endmodule

// File: tb/tb_n2_com_dp_32x152_fifo_ctl.sv
// Directed bench for the 32 x 152 FIFO controller with a behavioural array.
module tb_n2_com_dp_32x152_fifo_ctl;
   import n2_com_fifo_pkg::*;

   logic          l2clk = 1'b0;
   logic          reset;
   logic          push_vld;
   logic          push_rdy;
   logic          wr_en;
   logic [AW-1:0] wr_adr;
   logic          rd_en;
   logic [AW-1:0] rd_adr;
   logic [DW-1:0] arr_dout;
   logic          wr_inhibit;
   logic          pop_vld;
   logic          pop_rdy;
   logic [DW-1:0] pop_data;
   logic [AW:0]   count;
   logic          empty;
   logic          full;

   logic [DW-1:0] din;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] sbq [$];

   int n_cmp;
   int n_err;
   int exp_wp;
   int exp_rp;
   int n_pop;
   int n_rd;

   always #5 l2clk = ~l2clk;

   n2_com_dp_32x152_fifo_ctl dut (
      .l2clk      (l2clk),
      .reset      (reset),
      .push_vld   (push_vld),
      .push_rdy   (push_rdy),
      .wr_en      (wr_en),
      .wr_adr     (wr_adr),
      .rd_en      (rd_en),
      .rd_adr     (rd_adr),
      .arr_dout   (arr_dout),
      .wr_inhibit (wr_inhibit),
      .pop_vld    (pop_vld),
      .pop_rdy    (pop_rdy),
      .pop_data   (pop_data),
      .count      (count),
      .empty      (empty),
      .full       (full)
   );

   // Register-file array: write port plus registered read port.
   always @(posedge l2clk) begin
      if (wr_en) mem[wr_adr] <= din;
      if (rd_en) arr_dout <= mem[rd_adr];
   end

   function automatic logic [DW-1:0] mk(input int k);
      return {24'hC0FFEE, {4{k}}};
   endfunction

   // Observe handshakes of the current cycle, then advance one clock.
   task automatic tick();
      logic [DW-1:0] exp_d;
      #1;
      if (reset) begin
         @(posedge l2clk); #1;
         sbq.delete();
         exp_wp = 0;
         exp_rp = 0;
      end else begin
         if (wr_en) begin
            n_cmp++;
            if (!push_vld || wr_adr !== AW'(exp_wp)) begin
               n_err++;
               $display("FAIL wr_adr: got %0d (push_vld %0b), need %0d (push_vld 1)", wr_adr, push_vld, exp_wp);
            end
            exp_wp = (exp_wp + 1) % 32;
            sbq.push_back(din);
         end
         if (rd_en) begin
            n_cmp++;
            if (rd_adr !== AW'(exp_rp)) begin
               n_err++;
               $display("FAIL rd_adr: got %0d, need %0d", rd_adr, exp_rp);
            end
            exp_rp = (exp_rp + 1) % 32;
            n_rd++;
         end
         if (pop_vld && pop_rdy) begin
            n_pop++;
            n_cmp++;
            if (sbq.size() == 0) begin
               n_err++;
               $display("FAIL pop_extra: got pop of %h, need no pop", pop_data);
            end else begin
               exp_d = sbq.pop_front();
               if (pop_data !== exp_d) begin
                  n_err++;
                  $display("FAIL pop_data: got %h, need %h", pop_data, exp_d);
               end
            end
         end
         @(posedge l2clk); #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; push_vld = 1'b0; pop_rdy = 1'b0; wr_inhibit = 1'b0; din = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic drain(input string tag);
      int g;
      g = 0;
      push_vld = 1'b0; wr_inhibit = 1'b0; pop_rdy = 1'b1;
      #1;
      while (!empty && g < 100) begin
         tick(); #1; g++;
      end
      n_cmp++;
      if (!empty || sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain_%s: got empty %0b left %0d, need empty 1 left 0", tag, empty, sbq.size());
      end
      tick();
      pop_rdy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; push_vld = 1'b1; pop_rdy = 1'b1; wr_inhibit = 1'b0; din = '0;
      #1;
      n_cmp++; if (push_rdy !== 1'b0) begin n_err++; $display("FAIL rst_push_rdy: got %b, need 0", push_rdy); end
      n_cmp++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got wr %b rd %b, need 0 0", wr_en, rd_en); end
      n_cmp++; if (pop_vld !== 1'b0) begin n_err++; $display("FAIL rst_pop_vld: got %b, need 0", pop_vld); end
      tick();
      reset = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0;
      #1;
      n_cmp++; if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL post_rst_cnt: got count %0d empty %b full %b, need 0 1 0", count, empty, full); end
      n_cmp++; if (pop_vld !== 1'b0 || pop_data !== '0) begin n_err++; $display("FAIL post_rst_pop: got vld %b data %h, need 0 0", pop_vld, pop_data); end
      n_cmp++; if (push_rdy !== 1'b1 || rd_en !== 1'b0) begin n_err++; $display("FAIL post_rst_rdy: got push_rdy %b rd_en %b, need 1 0", push_rdy, rd_en); end
      tick();
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      d = {19{8'hA5}};
      pop_rdy = 1'b1; push_vld = 1'b1; din = d;
      #1;
      n_cmp++; if (wr_en !== 1'b1 || wr_adr !== 5'd0 || rd_en !== 1'b0) begin n_err++; $display("FAIL single_c0: got wr_en %b wr_adr %0d rd_en %b, need 1 0 0", wr_en, wr_adr, rd_en); end
      tick();
      push_vld = 1'b0;
      #1;
      n_cmp++; if (rd_en !== 1'b1 || rd_adr !== 5'd0 || pop_vld !== 1'b0) begin n_err++; $display("FAIL single_c1: got rd_en %b rd_adr %0d pop_vld %b, need 1 0 0", rd_en, rd_adr, pop_vld); end
      tick();
      #1;
      n_cmp++; if (pop_vld !== 1'b1 || pop_data !== d) begin n_err++; $display("FAIL single_c2: got pop_vld %b data %h, need 1 %h", pop_vld, pop_data, d); end
      tick();
      #1;
      n_cmp++; if (empty !== 1'b1 || count !== 6'd0 || pop_vld !== 1'b0) begin n_err++; $display("FAIL single_c3: got empty %b count %0d pop_vld %b, need 1 0 0", empty, count, pop_vld); end
      tick();
      pop_rdy = 1'b0;
   endtask

   task automatic test_fill();
      do_reset();
      pop_rdy = 1'b0; push_vld = 1'b1;
      for (int k = 0; k < 34; k++) begin
         din = mk(k);
         #1;
         n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL fill_accept_%0d: got wr_en %b, need 1", k, wr_en); end
         tick();
      end
      din = mk(34);
      #1;
      n_cmp++; if (full !== 1'b1 || push_rdy !== 1'b0 || wr_en !== 1'b0) begin n_err++; $display("FAIL fill_full: got full %b push_rdy %b wr_en %b, need 1 0 0", full, push_rdy, wr_en); end
      n_cmp++; if (count !== 6'd34) begin n_err++; $display("FAIL fill_count: got %0d, need 34", count); end
      n_cmp++; if (pop_vld !== 1'b1 || pop_data !== mk(0)) begin n_err++; $display("FAIL fill_head: got vld %b data %h, need 1 %h", pop_vld, pop_data, mk(0)); end
      tick();
      #1;
      n_cmp++; if (wr_en !== 1'b0 || count !== 6'd34) begin n_err++; $display("FAIL fill_hold: got wr_en %b count %0d, need 0 34", wr_en, count); end
      tick();
   endtask

   task automatic test_wrap();
      int k, p0;
      k = 34; p0 = n_pop;
      for (int c = 0; c < 40; c++) begin
         din = mk(k); push_vld = 1'b1; pop_rdy = 1'b1;
         #1;
         n_cmp++; if (pop_vld !== 1'b1) begin n_err++; $display("FAIL wrap_stream_%0d: got pop_vld %b, need 1", c, pop_vld); end
         if (push_rdy) k++;
         tick();
      end
      n_cmp++; if (n_pop - p0 != 40) begin n_err++; $display("FAIL wrap_rate: got %0d pops, need 40", n_pop - p0); end
      drain("wrap");
   endtask

   task automatic test_toggle();
      int k, cyc, p0, r0, maxc;
      k = 0; cyc = 0; p0 = n_pop; r0 = n_rd; maxc = 0;
      while ((n_pop - p0) < 64 && cyc < 600) begin
         push_vld = (k < 64); din = mk(1000 + k); pop_rdy = (cyc % 2 == 0);
         #1;
         if (push_vld && push_rdy) k++;
         if (int'(count) > maxc) maxc = int'(count);
         tick();
         cyc++;
      end
      push_vld = 1'b0; pop_rdy = 1'b0;
      n_cmp++; if (n_pop - p0 != 64 || k != 64) begin n_err++; $display("FAIL toggle_total: got %0d pops %0d pushes, need 64 64", n_pop - p0, k); end
      n_cmp++; if (n_rd - r0 != 64) begin n_err++; $display("FAIL toggle_reads: got %0d, need 64", n_rd - r0); end
      n_cmp++; if (maxc > 34 || maxc < 3) begin n_err++; $display("FAIL toggle_count: got max %0d, need 3..34", maxc); end
      drain("toggle");
   endtask

   task automatic test_inhibit();
      for (int c = 0; c < 6; c++) begin
         push_vld = 1'b1; pop_rdy = 1'b1; din = mk(2000 + c);
         tick();
      end
      wr_inhibit = 1'b1;
      for (int c = 0; c < 5; c++) begin
         din = mk(2100 + c);
         #1;
         n_cmp++; if (push_rdy !== 1'b0 || wr_en !== 1'b0) begin n_err++; $display("FAIL inhibit_%0d: got push_rdy %b wr_en %b, need 0 0", c, push_rdy, wr_en); end
         n_cmp++; if (pop_vld !== (c < 2)) begin n_err++; $display("FAIL inhibit_drain_%0d: got pop_vld %b, need %b", c, pop_vld, (c < 2)); end
         tick();
      end
      wr_inhibit = 1'b0; din = mk(2200);
      #1;
      n_cmp++; if (wr_en !== 1'b1 || wr_adr !== AW'(exp_wp)) begin n_err++; $display("FAIL inhibit_resume: got wr_en %b wr_adr %0d, need 1 %0d", wr_en, wr_adr, exp_wp); end
      tick();
      drain("inhibit");
   endtask

   task automatic test_reset_mid();
      int p0;
      do_reset();
      pop_rdy = 1'b0; push_vld = 1'b1;
      for (int k = 0; k < 11; k++) begin
         din = mk(100 + k);
         tick();
      end
      push_vld = 1'b0; pop_rdy = 1'b1;
      #1;
      n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL mid_read: got rd_en %b, need 1", rd_en); end
      tick();
      pop_rdy = 1'b0;
      #1;
      n_cmp++; if (count !== 6'd10) begin n_err++; $display("FAIL mid_count: got %0d, need 10", count); end
      reset = 1'b1; push_vld = 1'b1;
      #1;
      n_cmp++; if (push_rdy !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0 || pop_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst: got push_rdy %b wr %b rd %b pop_vld %b, need 0 0 0 0", push_rdy, wr_en, rd_en, pop_vld); end
      tick();
      reset = 1'b0; push_vld = 1'b0;
      #1;
      n_cmp++; if (count !== 6'd0 || empty !== 1'b1 || pop_vld !== 1'b0) begin n_err++; $display("FAIL mid_after: got count %0d empty %b pop_vld %b, need 0 1 0", count, empty, pop_vld); end
      n_cmp++; if (rd_adr !== 5'd0 || wr_adr !== 5'd0 || pop_data !== '0) begin n_err++; $display("FAIL mid_ptrs: got rd_adr %0d wr_adr %0d data %h, need 0 0 0", rd_adr, wr_adr, pop_data); end
      tick();
      p0 = n_pop;
      push_vld = 1'b1; din = mk(200);
      tick();
      push_vld = 1'b0; pop_rdy = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      n_cmp++; if (n_pop - p0 != 1) begin n_err++; $display("FAIL mid_new: got %0d pops, need 1", n_pop - p0); end
      pop_rdy = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; exp_wp = 0; exp_rp = 0; n_pop = 0; n_rd = 0;
      arr_dout = '0;
      test_reset();
      test_single();
      test_fill();
      test_wrap();
      test_toggle();
      test_inhibit();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, need finish");
      $fatal(1, "watchdog");
   end

endmodule
